// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen
// Pseudo-random number generator for game logic. A Galois LFSR runs every
// cycle. A draw engine turns its low bits into a value uniformly distributed
// in [0, bound). It uses masked rejection sampling, so there is no modulo bias.
// An optional no-repeat mode forbids returning the previous value twice in a
// row. After MAX_TRIES rejected candidates a deterministic fallback value is
// produced, so every draw finishes in bounded time.
//
// Ports
//   clk        clock
//   rst        synchronous active-low reset
//   seed_load  load seed_in (zero seed is replaced by SEED); aborts a draw
//   seed_in    new LFSR state
//   bound      exclusive upper limit of a draw, sampled when req is accepted
//   no_repeat  forbid rnd == previous rnd, sampled when req is accepted
//   req        draw request, level-sampled while idle
//   busy       high while a draw is in progress
//   valid      one-cycle pulse, rnd updated in the same cycle
//   rnd        last drawn value, held until the next valid
//   err        one-cycle pulse: req accepted with bound == 0
//   fallback   one-cycle pulse together with valid when the fallback path was used
//   lfsr_state current LFSR state (debug / verification)
//
// Handshake: req is sampled only while busy is low. A request with a non-zero
// bound and seed_load low is accepted on that edge, and busy rises. Requests
// seen while busy are dropped and are not queued. Each accepted request ends
// with exactly one valid pulse, unless seed_load or reset aborts it first.
// busy is already low in the cycle where valid is high, so a held req is
// accepted on the very next edge.

module lfsr_rng_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'h00FF,
  parameter int                OUT_W     = 4,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [OUT_W-1:0]  bound,
  input  logic              no_repeat,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  rnd,
  output logic              err,
  output logic              fallback,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(OUT_W - 1);
  localparam logic [TRY_W-1:0] TRY_LAST   = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W-1:0] ONE        = OUT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  shift_cnt;
  logic [TRY_W-1:0]  tries;
  logic [OUT_W-1:0]  bound_q;
  logic              nr_q;
  logic [OUT_W-1:0]  res_q;
  logic              fb_q;

  // Smallest all-ones pattern covering v: smear the top set bit downwards.
  function automatic logic [OUT_W-1:0] fill_mask(input logic [OUT_W-1:0] v);
    logic [OUT_W-1:0] m;
    m = v;
    for (int i = 1; i < OUT_W; i++) begin
      m = m | (v >> i);
    end
    return m;
  endfunction

  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] seed_val;
  logic [OUT_W-1:0]  bound_m1;
  logic [OUT_W-1:0]  mask;
  logic [OUT_W-1:0]  cand;
  logic [OUT_W-1:0]  over;
  logic [OUT_W-1:0]  wrap_val;
  logic [OUT_W-1:0]  fb_val;
  logic              is_rep;
  logic              accept;

  assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
  // A zero state would lock the LFSR up, so zero seeds become SEED.
  assign seed_val  = (seed_in == '0) ? SEED : seed_in;

  // mask >= bound-1 and mask < 2*bound, so a candidate is accepted with
  // probability > 1/2. Because cand < 2*bound, cand-bound is always in range.
  assign bound_m1 = bound_q - ONE;
  assign mask     = fill_mask(bound_m1);
  assign cand     = lfsr[OUT_W-1:0] & mask;
  // rnd doubles as the previous value for no-repeat comparisons.
  assign is_rep   = nr_q && (bound_q != ONE) && (cand == rnd);
  assign accept   = (cand < bound_q) && !is_rep;

  // Fallback: fold an out-of-range candidate back into range. If that still
  // repeats (or the candidate was rejected only as a repeat), step one past
  // the previous value, wrapping at bound.
  assign wrap_val = (rnd == bound_m1) ? '0 : rnd + ONE;
  assign over     = cand - bound_q;
  assign fb_val   = (cand >= bound_q) ? ((nr_q && (over == rnd)) ? wrap_val : over)
                                      : wrap_val;

  assign busy       = (state != IDLE);
  assign lfsr_state = lfsr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr      <= SEED;
      state     <= IDLE;
      shift_cnt <= '0;
      tries     <= '0;
      bound_q   <= '0;
      nr_q      <= 1'b0;
      res_q     <= '0;
      fb_q      <= 1'b0;
      rnd       <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      fallback  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      err      <= 1'b0;
      fallback <= 1'b0;
      if (seed_load) begin
        // Seed load wins over stepping and silently abandons any draw.
        lfsr      <= seed_val;
        state     <= IDLE;
        shift_cnt <= '0;
        tries     <= '0;
      end else begin
        lfsr <= lfsr_next;
        case (state)
          IDLE: begin
            if (req) begin
              if (bound == '0) begin
                err <= 1'b1;
              end else begin
                bound_q   <= bound;
                nr_q      <= no_repeat;
                tries     <= '0;
                shift_cnt <= '0;
                state     <= SHIFT;
              end
            end
          end
          SHIFT: begin
            // Let OUT_W steps pass so the next candidate uses fresh bits.
            if (shift_cnt == SHIFT_LAST) begin
              state <= CHECK;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (accept) begin
              res_q <= cand;
              fb_q  <= 1'b0;
              state <= DONE;
            end else if (tries == TRY_LAST) begin
              res_q <= fb_val;
              fb_q  <= 1'b1;
              state <= DONE;
            end else begin
              tries     <= tries + 1'b1;
              shift_cnt <= '0;
              state     <= SHIFT;
            end
          end
          DONE: begin
            rnd      <= res_q;
            valid    <= 1'b1;
            fallback <= fb_q;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
module tb_lfsr_rng_gen;

  localparam int          LW   = 16;
  localparam int          OW   = 4;
  localparam int          MAXT = 8;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'h00FF;
  // Queue entry: {no_repeat, bound, fallback, value, valid cycle}
  localparam int          QW   = 32 + OW + 1 + OW + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          seed_load;
  logic [LW-1:0] seed_in;
  logic [OW-1:0] bound;
  logic          no_repeat;
  logic          req;
  logic          busy;
  logic          valid;
  logic [OW-1:0] rnd;
  logic          err;
  logic          fallback;
  logic [LW-1:0] lfsr_state;

  always #5 clk = ~clk;

  lfsr_rng_gen #(
    .LFSR_W(LW), .TAPS(TAPS), .SEED(SEED), .OUT_W(OW), .MAX_TRIES(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .bound(bound), .no_repeat(no_repeat), .req(req), .busy(busy),
    .valid(valid), .rnd(rnd), .err(err), .fallback(fallback),
    .lfsr_state(lfsr_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic [LW-1:0] m_lfsr;
  int          m_last = 0;
  int          saved_last = 0;
  int          mon_last = 0;
  int          busy_from = 0;
  int          busy_to = 0;
  int          err_cyc = -1;
  bit          mon_en = 0;
  bit          hist_en = 0;
  int          mdl_hist[16];
  int          dut_hist[16];
  int          mdl_fb = 0;
  int          dut_fb = 0;
  logic [QW-1:0] exp_q[$];

  function automatic logic [LW-1:0] stepn(input logic [LW-1:0] s, input int n);
    logic [LW-1:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = (r >> 1) ^ (r[0] ? TAPS : 16'h0);
    return r;
  endfunction

  // LFSR value after each edge, following the documented update rules.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst)           m_lfsr <= SEED;
    else if (seed_load) m_lfsr <= (seed_in == '0) ? SEED : seed_in;
    else                m_lfsr <= stepn(m_lfsr, 1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for the next edge and predict its outcome.
  task automatic issue(input int b, input bit nr, output int v);
    int k, m, cand, val, tries_used, wrapped;
    bit found, fb;
    logic [LW-1:0] s;
    logic [QW-1:0] it;
    k = cyc + 1;
    req = 1'b1;
    bound = OW'(b);
    no_repeat = nr;
    if (b == 0) begin
      err_cyc = k;
      v = k;
      return;
    end
    m = 0;
    while (m < b - 1) m = m * 2 + 1;
    s = m_lfsr;
    found = 0;
    cand = 0;
    tries_used = MAXT - 1;
    for (int t = 0; t < MAXT && !found; t++) begin
      // Each candidate is read OW+1 steps after the previous decision point.
      s = stepn(s, OW + 1);
      cand = int'(s[OW-1:0]) & m;
      if (cand < b && (!nr || b == 1 || cand != m_last)) begin
        found = 1;
        tries_used = t;
      end
    end
    wrapped = (m_last == b - 1) ? 0 : m_last + 1;
    if (found) begin
      val = cand;
      fb = 0;
    end else begin
      fb = 1;
      if (cand >= b) begin
        val = cand - b;
        if (nr && val == m_last) val = wrapped;
      end else begin
        val = wrapped;
      end
    end
    v = k + OW + 2 + tries_used * (OW + 1);
    busy_from = k;
    busy_to = v;
    saved_last = m_last;
    m_last = val;
    if (hist_en) begin
      mdl_hist[val]++;
      mdl_fb += int'(fb);
    end
    it = '0;
    it[31:0] = v;
    it[32 +: OW] = OW'(val);
    it[32 + OW] = fb;
    it[33 + OW +: OW] = OW'(b);
    it[33 + 2 * OW] = nr;
    exp_q.push_back(it);
  endtask

  task automatic run_draw(input int b, input bit nr, input bit hold);
    int v;
    issue(b, nr, v);
    tick();
    if (!hold) req = 1'b0;
    // Changing these mid-draw must not matter.
    bound = OW'($urandom);
    no_repeat = 1'($urandom);
    while (cyc < v) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [QW-1:0] it;
    int e_cyc, e_val, e_bnd;
    bit e_fb, e_nr;
    if (mon_en) begin
      chk("lfsr_state", lfsr_state, m_lfsr);
      chk("busy", busy, (cyc >= busy_from && cyc < busy_to));
      chk("err", err, (cyc == err_cyc));
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", valid, 0);
        end else begin
          it = exp_q.pop_front();
          e_cyc = int'(it[31:0]);
          e_val = int'(it[32 +: OW]);
          e_fb  = it[32 + OW];
          e_bnd = int'(it[33 + OW +: OW]);
          e_nr  = it[33 + 2 * OW];
          chk("valid_cycle", cyc, e_cyc);
          chk("rnd", rnd, e_val);
          chk("fallback", fallback, e_fb);
          chk("rnd_in_range", (int'(rnd) < e_bnd), 1);
          if (e_nr && e_bnd > 1) chk("no_repeat", (int'(rnd) != mon_last), 1);
          mon_last = e_val;
          if (hist_en) begin
            dut_hist[rnd]++;
            dut_fb += int'(fallback);
          end
        end
      end else begin
        chk("rnd_hold", rnd, mon_last);
        chk("fallback_idle", fallback, 0);
        if (exp_q.size() > 0) begin
          if (int'(exp_q[0][31:0]) < cyc) begin
            chk("valid_missing", valid, 1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v;
    rst = 1'b0;
    seed_load = 1'b0;
    seed_in = '0;
    bound = '0;
    no_repeat = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mdl_hist[i] = 0;
      dut_hist[i] = 0;
    end

    // Reset state
    tick();
    tick();
    chk("reset_lfsr", lfsr_state, 16'h00FF);
    chk("reset_rnd", rnd, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    chk("reset_fallback", fallback, 0);
    mon_en = 1;
    rst = 1'b1;
    tick();
    chk("lfsr_step1", lfsr_state, 16'hB47F);
    tick();

    // Seed loading
    seed_load = 1'b1;
    seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("seed_zero_subst", lfsr_state, 16'h00FF);
    seed_load = 1'b1;
    seed_in = 16'h1234;
    tick();
    seed_load = 1'b0;
    chk("seed_1234", lfsr_state, 16'h1234);
    tick();

    // bound == 0 -> error pulse only
    issue(0, 0, v);
    tick();
    req = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    tick();
    chk("err_clear", err, 0);
    tick();

    // bound == 1 always 0 on the first try
    for (int i = 0; i < 10; i++) run_draw(1, 1'($urandom), 0);
    // Bounds that are or nearly are powers of two
    for (int i = 0; i < 20; i++) run_draw(8, 0, 0);
    for (int i = 0; i < 20; i++) run_draw(15, 0, 1);
    req = 1'b0;
    tick();

    // bound == 2 with no_repeat, back to back
    for (int i = 0; i < 1000; i++) run_draw(2, 1, 1);
    req = 1'b0;
    tick();

    // bound == 9 distribution, back to back
    hist_en = 1;
    for (int i = 0; i < 2000; i++) run_draw(9, 0, 1);
    req = 1'b0;
    tick();
    tick();
    hist_en = 0;
    for (int i = 0; i < 16; i++) chk($sformatf("hist_%0d", i), dut_hist[i], mdl_hist[i]);
    chk("fallback_count", dut_fb, mdl_fb);

    // Random mix, with occasional reseeding while idle
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        req = 1'b0;
        seed_load = 1'b1;
        seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : LW'($urandom);
        tick();
        seed_load = 1'b0;
      end
      run_draw($urandom_range(1, 15), 1'($urandom), 1'($urandom));
    end
    req = 1'b0;
    tick();

    // seed_load during SHIFT aborts the draw
    issue(5, 0, v);
    tick();
    req = 1'b0;
    tick();
    seed_load = 1'b1;
    seed_in = 16'hACE1;
    tick();
    seed_load = 1'b0;
    exp_q.delete();
    busy_to = cyc;
    m_last = saved_last;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_lfsr", lfsr_state, 16'hACE1);
    for (int i = 0; i < 3; i++) tick();
    run_draw(6, 1, 0);

    // Reset mid-draw
    issue(7, 1, v);
    tick();
    req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
    busy_to = cyc;
    m_last = 0;
    mon_last = 0;
    chk("rst_mid_rnd", rnd, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_lfsr", lfsr_state, 16'h00FF);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) run_draw($urandom_range(1, 15), 1'($urandom), 0);

    repeat (50) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
